game_turn_controller: RTL

- Owns the 5x5 game board register and sequences each game: start, player turns, move validation, win check, game over.
- Accepts moves from both players through a valid/ready port and alternates turns.
- After every legal move, requests a win check from the board win-checking datapath through a req/done handshake; done may arrive any number of cycles later.
- Detects a draw when the board is full and forfeits a turn on timeout.

---
 rtl/game_turn_controller.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/game_turn_controller.sv
// game_turn_controller
// Owns the 5x5 board and sequences a two-player game: start, alternating
// turns through a valid/ready move port, move validation, a req/done
// handshake with an external win checker, draw detection and turn timeout.
module game_turn_controller #(
  parameter int TURN_TIMEOUT = 1000,
  parameter int FIRST_PLAYER = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mv_valid,
  input  logic [1:0]  mv_player,
  input  logic [2:0]  mv_row,
  input  logic [2:0]  mv_col,
  output logic        mv_ready,
  output logic        mv_ack,
  output logic        mv_err,
  output logic [1:0]  err_code,
  output logic [74:0] board,
  output logic [1:0]  cur_player,
  output logic        chk_req,
  output logic [1:0]  chk_player,
  input  logic        chk_done,
  input  logic        chk_won,
  output logic [4:0]  move_count,
  output logic        timeout_skip,
  output logic        game_over,
  output logic [1:0]  winner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TURN  = 2'd1,
    S_CHECK = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TURN_TIMEOUT - 1);
  localparam logic [1:0]  FIRST_ID   = 2'(FIRST_PLAYER);
  localparam logic [4:0]  CELLS      = 5'd25;

  localparam logic [1:0]  ERR_NONE   = 2'b00;
  localparam logic [1:0]  ERR_PLAYER = 2'b01;
  localparam logic [1:0]  ERR_RANGE  = 2'b10;
  localparam logic [1:0]  ERR_OCC    = 2'b11;

  // Linear cell number for an in-range (row, col); only meaningful when both <= 4.
  function automatic logic [4:0] cell_index(input logic [2:0] row, input logic [2:0] col);
    return ({2'b00, row} * 5'd5) + {2'b00, col};
  endfunction

  // Opponent of a player id; anything other than 1 is treated as player 2.
  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == 2'd1) ? 2'd2 : 2'd1;
  endfunction

  // Read the 3-bit owner field of one cell.
  function automatic logic [2:0] cell_read(input logic [74:0] b, input logic [4:0] idx);
    logic [2:0] v;
    v = 3'b000;
    for (int i = 0; i < 25; i++) begin
      if (idx == 5'(i)) begin
        v = b[3*i +: 3];
      end else begin
        v = v;
      end
    end
    return v;
  endfunction

  state_t       r_state;
  state_t       w_next_state;
  logic [74:0]  r_board;
  logic [1:0]   r_player;
  logic [4:0]   r_count;
  logic [1:0]   r_winner;
  logic [1:0]   r_err_code;
  logic         r_ack;
  logic         r_err;
  logic         r_skip;
  logic [15:0]  r_timer;

  logic         w_in_range;
  logic [4:0]   w_idx;
  logic [2:0]   w_cell;
  logic         w_take;
  logic         w_err_player;
  logic         w_err_range;
  logic         w_err_occ;
  logic         w_legal;
  logic         w_reject;
  logic [1:0]   w_code;
  logic         w_timeout;

  // Move decode: handshake, validation in priority order, and timeout detection.
  always_comb begin
    w_in_range   = (mv_row <= 3'd4) && (mv_col <= 3'd4);
    w_idx        = w_in_range ? cell_index(mv_row, mv_col) : 5'd0;
    w_cell       = cell_read(r_board, w_idx);
    w_take       = (r_state == S_TURN) && mv_valid && !start;
    w_err_player = (mv_player != r_player);
    w_err_range  = !w_in_range;
    w_err_occ    = (w_cell != 3'b000);
    if (w_err_player) begin
      w_code = ERR_PLAYER;
    end else if (w_err_range) begin
      w_code = ERR_RANGE;
    end else if (w_err_occ) begin
      w_code = ERR_OCC;
    end else begin
      w_code = ERR_NONE;
    end
    w_legal   = w_take && (w_code == ERR_NONE);
    w_reject  = w_take && (w_code != ERR_NONE);
    // A legal move on the last timer cycle beats the timeout.
    w_timeout = (r_state == S_TURN) && !start && (r_timer == TIMER_LAST) && !w_legal;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; start wins in every state.
  always_comb begin
    w_next_state = r_state;
    if (start) begin
      w_next_state = S_TURN;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next_state = S_IDLE;
        end
        S_TURN: begin
          if (w_legal) begin
            w_next_state = S_CHECK;
          end else begin
            w_next_state = S_TURN;
          end
        end
        S_CHECK: begin
          if (!chk_done) begin
            w_next_state = S_CHECK;
          end else if (chk_won || (r_count == CELLS)) begin
            w_next_state = S_OVER;
          end else begin
            w_next_state = S_TURN;
          end
        end
        S_OVER: begin
          w_next_state = S_OVER;
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  // Game datapath: board, counters, player, winner, timer and result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_board    <= 75'd0;
      r_player   <= 2'd0;
      r_count    <= 5'd0;
      r_winner   <= 2'd0;
      r_err_code <= 2'b00;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_skip     <= 1'b0;
      r_timer    <= 16'd0;
    end else begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_skip <= 1'b0;
      if (start) begin
        r_board  <= 75'd0;
        r_count  <= 5'd0;
        r_winner <= 2'd0;
        r_timer  <= 16'd0;
        r_player <= FIRST_ID;
      end else begin
        case (r_state)
          S_TURN: begin
            if (w_legal) begin
              for (int i = 0; i < 25; i++) begin
                if (w_idx == 5'(i)) begin
                  r_board[3*i +: 3] <= {1'b0, mv_player};
                end
              end
              r_count <= r_count + 5'd1;
              r_ack   <= 1'b1;
              r_timer <= 16'd0;
            end else begin
              if (w_reject) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
              end
              // A rejected move does not restart the timer.
              if (w_timeout) begin
                r_player <= other_player(r_player);
                r_skip   <= 1'b1;
                r_timer  <= 16'd0;
              end else begin
                r_timer <= r_timer + 16'd1;
              end
            end
          end
          S_CHECK: begin
            if (chk_done) begin
              if (chk_won) begin
                r_winner <= r_player;
              end else if (r_count == CELLS) begin
                r_winner <= 2'd0;
              end else begin
                r_player <= other_player(r_player);
                r_timer  <= 16'd0;
              end
            end
          end
          S_IDLE, S_OVER: begin
            r_timer <= 16'd0;
          end
          default: begin
            r_timer <= 16'd0;
          end
        endcase
      end
    end
  end

  // FSM outputs decoded from the registered state and datapath.
  always_comb begin
    mv_ready   = (r_state == S_TURN);
    chk_req    = (r_state == S_CHECK);
    game_over  = (r_state == S_OVER);
    if ((r_state == S_TURN) || (r_state == S_CHECK)) begin
      cur_player = r_player;
    end else begin
      cur_player = 2'd0;
    end
    if (r_state == S_CHECK) begin
      chk_player = r_player;
    end else begin
      chk_player = 2'd0;
    end
    mv_ack       = r_ack;
    mv_err       = r_err;
    err_code     = r_err_code;
    timeout_skip = r_skip;
    board        = r_board;
    move_count   = r_count;
    winner       = r_winner;
  end

endmodule
